// File: rtl/channel_scanner_pkg.sv
// Shared constants and FSM state type for the channel scanner.
package scanner_pkg;
    localparam int NUM_CHANNELS = 16;
    localparam int CHANNEL_W    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } scanner_state_t;
endpackage

// File: rtl/channel_scanner_if.sv
// Scanner bus: select to mux16, data back from mux16, and the downstream
// sample valid/ready handshake.
interface channel_scanner_if #(parameter int N = 1);
    import scanner_pkg::*;

    logic                    ena;
    logic [NUM_CHANNELS-1:0] channel_mask;
    logic [N-1:0]            mux_out;
    logic [CHANNEL_W-1:0]    switch;
    logic [N-1:0]            sample_data;
    logic [CHANNEL_W-1:0]    sample_channel;
    logic                    sample_valid;
    logic                    sample_ready;

    modport master (
        input  ena, channel_mask, mux_out, sample_ready,
        output switch, sample_data, sample_channel, sample_valid
    );

    modport slave (
        output ena, channel_mask, mux_out, sample_ready,
        input  switch, sample_data, sample_channel, sample_valid
    );
endinterface

// File: rtl/channel_scanner_rr_next_channel.sv
// Round-robin pick: first set mask bit starting at current+1, wrapping mod 16.
module rr_next_channel
    import scanner_pkg::*;
(
    input  logic [CHANNEL_W-1:0]    current,
    input  logic [NUM_CHANNELS-1:0] mask,
    output logic [CHANNEL_W-1:0]    next,
    output logic                    any
);
    always_comb begin
        next = current;
        // Walk from farthest to nearest so the nearest set bit wins; offset 16
        // wraps to current itself, which covers a single-bit mask.
        for (int i = NUM_CHANNELS; i >= 1; i--) begin
            if (mask[CHANNEL_W'(current + CHANNEL_W'(i))])
                next = CHANNEL_W'(current + CHANNEL_W'(i));
        end
    end

    assign any = |mask;
endmodule

// File: rtl/channel_scanner.sv
// Drives mux16 select round-robin over enabled channels, waits the settle time,
// and hands each capture downstream tagged with its channel number.
module channel_scanner
    import scanner_pkg::*;
#(
    parameter int N             = 1,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    channel_scanner_if.master bus
);
    localparam int                 CNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 255)) begin : g_settle_chk
        $error("channel_scanner: SETTLE_CYCLES must be in 1..255");
    end

    scanner_state_t       state_q;
    logic [CHANNEL_W-1:0] switch_q;
    logic [N-1:0]         data_q;
    logic [CHANNEL_W-1:0] chan_q;
    logic                 valid_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [CHANNEL_W-1:0] pick;
    logic                 any_en;
    logic                 start_scan;

    rr_next_channel u_rr (
        .current (switch_q),
        .mask    (bus.channel_mask),
        .next    (pick),
        .any     (any_en)
    );

    assign start_scan = bus.ena && any_en;
    assign cnt_d      = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            switch_q <= '1;
            data_q   <= '0;
            chan_q   <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_scan) begin
                        switch_q <= pick;
                        cnt_q    <= '0;
                        state_q  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q == CNT_LAST) begin
                        data_q  <= bus.mux_out;
                        chan_q  <= switch_q;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                HOLD: begin
                    // Handshake edge doubles as the next select edge, so
                    // back-to-back samples cost no extra cycle.
                    if (valid_q && bus.sample_ready) begin
                        valid_q <= 1'b0;
                        if (start_scan) begin
                            switch_q <= pick;
                            cnt_q    <= '0;
                            state_q  <= SETTLE;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.switch         = switch_q;
    assign bus.sample_data    = data_q;
    assign bus.sample_channel = chan_q;
    assign bus.sample_valid   = valid_q;
endmodule

// File: tb/tb_channel_scanner.sv
// Directed bench: one scanner with a mux16 model (in_i = A0+i), one with
// SETTLE_CYCLES=3 and a bench-driven mux_out.
module tb_channel_scanner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    channel_scanner_if #(.N(8)) ifa ();
    channel_scanner_if #(.N(8)) ifb ();

    assign ifa.mux_out = 8'hA0 + {4'h0, ifa.switch};

    channel_scanner #(.N(8), .SETTLE_CYCLES(1)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    channel_scanner #(.N(8), .SETTLE_CYCLES(3)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a sample on scanner A and check it and its spacing.
    task automatic wait_sample(input string tag, input logic [3:0] ch,
                               input logic [7:0] d, input int gap);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ifa.sample_valid && n < 20);
        chk($sformatf("%s_valid", tag), 32'(ifa.sample_valid), 32'd1);
        chk($sformatf("%s_ch", tag), 32'(ifa.sample_channel), 32'(ch));
        chk($sformatf("%s_data", tag), 32'(ifa.sample_data), 32'(d));
        chk($sformatf("%s_gap", tag), 32'(n), 32'(gap));
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        ifa.ena = 1'b0; ifa.channel_mask = '0; ifa.sample_ready = 1'b0;
        ifb.ena = 1'b0; ifb.channel_mask = '0; ifb.sample_ready = 1'b0;
        ifb.mux_out = 8'h11;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_switch", 32'(ifa.switch), 32'hF);
        chk("rst_valid", 32'(ifa.sample_valid), 32'd0);
        chk("rst_data", 32'(ifa.sample_data), 32'd0);
        chk("rst_chan", 32'(ifa.sample_channel), 32'd0);
        rst = 1'b0;

        // Zero mask with ena: stays idle
        ifa.ena = 1'b1;
        ifa.sample_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("zmask_valid", 32'(ifa.sample_valid), 32'd0);
        chk("zmask_switch", 32'(ifa.switch), 32'hF);

        // Basic scan over all channels, one sample every 2 cycles
        ifa.channel_mask = 16'hFFFF;
        for (int i = 0; i < 17; i++)
            wait_sample($sformatf("scan%0d", i), 4'(i % 16), 8'hA0 + 8'(i % 16), 2);
        ifa.ena = 1'b0;
        repeat (2) @(negedge clk);
        chk("scan_idle_valid", 32'(ifa.sample_valid), 32'd0);
        chk("scan_idle_switch", 32'(ifa.switch), 32'd0);

        // Sparse mask 0,2,15,0,2
        pulse_reset();
        ifa.channel_mask = 16'h8005;
        ifa.ena = 1'b1;
        wait_sample("sp0", 4'd0, 8'hA0, 2);
        wait_sample("sp1", 4'd2, 8'hA2, 2);
        wait_sample("sp2", 4'd15, 8'hAF, 2);
        wait_sample("sp3", 4'd0, 8'hA0, 2);
        wait_sample("sp4", 4'd2, 8'hA2, 2);

        // Backpressure: 5 stalled cycles hold everything stable
        pulse_reset();
        ifa.channel_mask = 16'hFFFF;
        ifa.sample_ready = 1'b0;
        wait_sample("bp0", 4'd0, 8'hA0, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d_valid", i), 32'(ifa.sample_valid), 32'd1);
            chk($sformatf("bp_hold%0d_data", i), 32'(ifa.sample_data), 32'hA0);
            chk($sformatf("bp_hold%0d_switch", i), 32'(ifa.switch), 32'd0);
        end
        ifa.sample_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_switch", 32'(ifa.switch), 32'd1);
        chk("bp_hs_valid", 32'(ifa.sample_valid), 32'd0);
        wait_sample("bp1", 4'd1, 8'hA1, 1);

        // ena dropped mid-SETTLE: sample completes, then idle
        @(negedge clk);
        chk("ena_settle_switch", 32'(ifa.switch), 32'd2);
        chk("ena_settle_valid", 32'(ifa.sample_valid), 32'd0);
        ifa.ena = 1'b0;
        wait_sample("ena2", 4'd2, 8'hA2, 1);
        repeat (3) @(negedge clk);
        chk("ena_idle_valid", 32'(ifa.sample_valid), 32'd0);
        chk("ena_idle_switch", 32'(ifa.switch), 32'd2);

        // Single-bit mask repeats channel 4
        pulse_reset();
        ifa.channel_mask = 16'h0010;
        ifa.ena = 1'b1;
        for (int i = 0; i < 3; i++)
            wait_sample($sformatf("single%0d", i), 4'd4, 8'hA4, 2);
        chk("single_switch", 32'(ifa.switch), 32'd4);

        // Async reset while holding a sample
        pulse_reset();
        ifa.channel_mask = 16'h000C;
        wait_sample("rh0", 4'd2, 8'hA2, 2);
        @(negedge clk);
        ifa.sample_ready = 1'b0;
        wait_sample("rh1", 4'd3, 8'hA3, 1);
        #2 rst = 1'b1;
        #1;
        chk("rh_async_valid", 32'(ifa.sample_valid), 32'd0);
        chk("rh_async_switch", 32'(ifa.switch), 32'hF);
        chk("rh_async_data", 32'(ifa.sample_data), 32'd0);
        chk("rh_async_chan", 32'(ifa.sample_channel), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ifa.sample_ready = 1'b1;
        wait_sample("rh2", 4'd2, 8'hA2, 2);

        // SETTLE_CYCLES=3: capture the value present at select edge +3
        ifb.channel_mask = 16'h0001;
        ifb.sample_ready = 1'b1;
        ifb.ena = 1'b1;
        @(negedge clk);
        chk("s3_switch", 32'(ifb.switch), 32'd0);
        chk("s3_v1", 32'(ifb.sample_valid), 32'd0);
        ifb.mux_out = 8'h22;
        @(negedge clk);
        chk("s3_v2", 32'(ifb.sample_valid), 32'd0);
        ifb.mux_out = 8'h33;
        @(negedge clk);
        chk("s3_v3", 32'(ifb.sample_valid), 32'd0);
        @(negedge clk);
        chk("s3_valid", 32'(ifb.sample_valid), 32'd1);
        chk("s3_data", 32'(ifb.sample_data), 32'h33);
        chk("s3_chan", 32'(ifb.sample_channel), 32'd0);
        ifb.ena = 1'b0;
        @(negedge clk);
        chk("s3_done", 32'(ifb.sample_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
